// File: rtl/mem_stage_hs.sv
// Memory pipeline stage: turns one load/store/passthrough op at a time into a
// request/grant/response memory transaction and a registered writeback bundle.
module mem_stage_hs #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_load,
   input  logic                  in_store,
   input  logic [1:0]            in_size,
   input  logic                  in_unsigned,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   input  logic [31:0]           in_wdata,
   input  logic [31:0]           in_result,
   input  logic [4:0]            in_rd,
   input  logic                  in_rd_we,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_data,
   output logic [4:0]            out_rd,
   output logic                  out_rd_we,
   output logic                  out_fault,
   output logic                  bp_valid,
   output logic [4:0]            bp_rd,
   output logic [31:0]           bp_data
);

   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [1:0]              size_q, size_d;
   logic                    uns_q, uns_d;
   logic                    store_q, store_d;
   logic [4:0]              rd_q, rd_d;
   logic                    rd_we_q, rd_we_d;
   logic [3:0]              be_q, be_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    out_valid_q, out_valid_d;
   logic [31:0]             out_data_q, out_data_d;
   logic [4:0]              out_rd_q, out_rd_d;
   logic                    out_rd_we_q, out_rd_we_d;
   logic                    out_fault_q, out_fault_d;

   logic                    accept_c;
   logic                    bad_c;
   logic [3:0]              be_c;
   logic [31:0]             wdata_c;
   logic [31:0]             lane_c;
   logic [31:0]             load_ext_c;

   assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept_c = in_valid && in_ready;

   // Illegal op class, illegal size, or address not aligned to the access size
   assign bad_c = (in_load && in_store) ||
                  ((in_load || in_store) &&
                   ((in_size == 2'b11) ||
                    ((in_size == 2'b01) && in_addr[0]) ||
                    ((in_size == 2'b10) && (in_addr[1:0] != 2'b00))));

   always_comb begin
      be_c    = 4'b1111;
      wdata_c = in_wdata;
      case (in_size)
         2'b00: begin
            be_c    = 4'b0001 << in_addr[1:0];
            wdata_c = {4{in_wdata[7:0]}};
         end
         2'b01: begin
            be_c    = 4'b0011 << in_addr[1:0];
            wdata_c = {2{in_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Shift the addressed lane down to bit 0, then extend to the access size
   assign lane_c = mem_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      load_ext_c = lane_c;
      case (size_q)
         2'b00:   load_ext_c = uns_q ? {24'd0, lane_c[7:0]}  : {{24{lane_c[7]}}, lane_c[7:0]};
         2'b01:   load_ext_c = uns_q ? {16'd0, lane_c[15:0]} : {{16{lane_c[15]}}, lane_c[15:0]};
         default: ;
      endcase
   end

   // Ops are only accepted when the output register is free, so every
   // completion below finds it free and can load it unconditionally.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      size_d      = size_q;
      uns_d       = uns_q;
      store_d     = store_q;
      rd_d        = rd_q;
      rd_we_d     = rd_we_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;
      out_rd_d    = out_rd_q;
      out_rd_we_d = out_rd_we_q;
      out_fault_d = out_fault_q;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               addr_d  = in_addr;
               size_d  = in_size;
               uns_d   = in_unsigned;
               store_d = in_store;
               rd_d    = in_rd;
               rd_we_d = in_rd_we;
               if (bad_c) begin
                  out_valid_d = 1'b1;
                  out_fault_d = 1'b1;
                  out_data_d  = 32'd0;
                  out_rd_d    = in_rd;
                  out_rd_we_d = 1'b0;
               end else if (!in_load && !in_store) begin
                  out_valid_d = 1'b1;
                  out_fault_d = 1'b0;
                  out_data_d  = in_result;
                  out_rd_d    = in_rd;
                  out_rd_we_d = in_rd_we;
               end else begin
                  state_d = REQ;
                  be_d    = be_c;
                  wdata_d = wdata_c;
               end
            end
         end
         REQ: begin
            if (mem_gnt) begin
               if (store_q) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b1;
                  out_fault_d = 1'b0;
                  out_data_d  = 32'd0;
                  out_rd_d    = rd_q;
                  out_rd_we_d = 1'b0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = '0;
               end
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_d     = IDLE;
               out_valid_d = 1'b1;
               out_fault_d = 1'b0;
               out_data_d  = load_ext_c;
               out_rd_d    = rd_q;
               out_rd_we_d = rd_we_q;
            end else if ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT)) begin
               state_d     = IDLE;
               cnt_d       = '0;
               out_valid_d = 1'b1;
               out_fault_d = 1'b1;
               out_data_d  = 32'd0;
               out_rd_d    = rd_q;
               out_rd_we_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         size_q      <= 2'b00;
         uns_q       <= 1'b0;
         store_q     <= 1'b0;
         rd_q        <= 5'd0;
         rd_we_q     <= 1'b0;
         be_q        <= 4'd0;
         wdata_q     <= 32'd0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
         out_rd_q    <= 5'd0;
         out_rd_we_q <= 1'b0;
         out_fault_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         store_q     <= store_d;
         rd_q        <= rd_d;
         rd_we_q     <= rd_we_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_rd_q    <= out_rd_d;
         out_rd_we_q <= out_rd_we_d;
         out_fault_q <= out_fault_d;
      end
   end

   assign mem_req   = (state_q == REQ);
   assign mem_we    = (state_q == REQ) && store_q;
   assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign mem_be    = be_q;
   assign mem_wdata = wdata_q;

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_rd    = out_rd_q;
   assign out_rd_we = out_rd_we_q;
   assign out_fault = out_fault_q;

   assign bp_valid  = out_valid_q && out_rd_we_q && (out_rd_q != 5'd0);
   assign bp_rd     = out_rd_q;
   assign bp_data   = out_data_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed self-checking bench for mem_stage_hs (TIMEOUT=4): loads, stores,
// passthrough, misalignment, timeout, output back-pressure and reset abort.
module tb_mem_stage_hs;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic        in_load = 1'b0, in_store = 1'b0;
   logic [1:0]  in_size = 2'b00;
   logic        in_unsigned = 1'b0;
   logic [31:0] in_addr = 32'd0, in_wdata = 32'd0, in_result = 32'd0;
   logic [4:0]  in_rd = 5'd0;
   logic        in_rd_we = 1'b0;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        out_valid, out_ready = 1'b1;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_rd_we, out_fault;
   logic        bp_valid;
   logic [4:0]  bp_rd;
   logic [31:0] bp_data;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage_hs #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_load(in_load), .in_store(in_store), .in_size(in_size),
      .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_result(in_result), .in_rd(in_rd), .in_rd_we(in_rd_we),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_rd(out_rd), .out_rd_we(out_rd_we), .out_fault(out_fault),
      .bp_valid(bp_valid), .bp_rd(bp_rd), .bp_data(bp_data)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op for exactly one cycle; returns in the cycle after acceptance.
   task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] result,
                        input logic [4:0] rd, input logic rd_we);
      in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
      in_addr = addr; in_wdata = wdata; in_result = result;
      in_rd = rd; in_rd_we = rd_we; in_valid = 1'b1;
      #1;
      chk("in_ready_at_issue", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Load with grant one cycle after request and response one cycle later.
   task automatic load_op(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_data);
      issue(1'b1, 1'b0, sz, uns, addr, 32'd0, 32'd0, 5'd5, 1'b1);
      chk({tag, "_req"}, 32'(mem_req), 32'd1);
      chk({tag, "_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
      chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk({tag, "_req_wait"}, 32'(mem_req), 32'd0);
      chk({tag, "_vld_wait"}, 32'(out_valid), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = rdata;
      tick();
      mem_rvalid = 1'b0;
      chk({tag, "_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, out_data, exp_data);
      chk({tag, "_rdwe"}, 32'(out_rd_we), 32'd1);
      chk({tag, "_fault"}, 32'(out_fault), 32'd0);
      chk({tag, "_bp"}, 32'(bp_valid), 32'd1);
      chk({tag, "_bpdata"}, bp_data, exp_data);
      tick();
      chk({tag, "_vld_clr"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_out_fault", 32'(out_fault), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_bp_valid", 32'(bp_valid), 32'd0);
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);

      // loads
      load_op("lw104", 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
      load_op("lb103", 2'b00, 1'b0, 32'h103, 32'h80123456, 4'b1000, 32'hFFFFFF80);
      load_op("lbu103", 2'b00, 1'b1, 32'h103, 32'h80123456, 4'b1000, 32'h00000080);
      load_op("lh102", 2'b01, 1'b0, 32'h102, 32'h80123456, 4'b1100, 32'hFFFF8012);
      load_op("lhu100", 2'b01, 1'b1, 32'h100, 32'h8012C456, 4'b0011, 32'h0000C456);
      load_op("lb101", 2'b00, 1'b0, 32'h101, 32'h00007F00, 4'b0010, 32'h0000007F);

      // half store, grant delayed so request must hold stable
      issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 32'd0, 5'd6, 1'b1);
      for (int i = 0; i < 2; i++) begin
         chk("sh_req", 32'(mem_req), 32'd1);
         chk("sh_we", 32'(mem_we), 32'd1);
         chk("sh_be", 32'(mem_be), 32'hC);
         chk("sh_wdata", mem_wdata, 32'hABCDABCD);
         chk("sh_addr", mem_addr, 32'h100);
         if (i == 0) tick();
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("sh_vld", 32'(out_valid), 32'd1);
      chk("sh_rdwe", 32'(out_rd_we), 32'd0);
      chk("sh_fault", 32'(out_fault), 32'd0);
      chk("sh_req_done", 32'(mem_req), 32'd0);
      tick();

      // byte store
      issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000EF, 32'd0, 5'd0, 1'b0);
      chk("sb_be", 32'(mem_be), 32'h2);
      chk("sb_wdata", mem_wdata, 32'hEFEFEFEF);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("sb_vld", 32'(out_valid), 32'd1);
      tick();

      // misaligned word load
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 32'd0, 5'd8, 1'b1);
      chk("mis_req", 32'(mem_req), 32'd0);
      chk("mis_vld", 32'(out_valid), 32'd1);
      chk("mis_fault", 32'(out_fault), 32'd1);
      chk("mis_data", out_data, 32'd0);
      chk("mis_rdwe", 32'(out_rd_we), 32'd0);
      chk("mis_bp", 32'(bp_valid), 32'd0);
      tick();
      chk("mis_req_later", 32'(mem_req), 32'd0);

      // illegal size and load+store both set
      issue(1'b0, 1'b1, 2'b11, 1'b0, 32'h200, 32'd0, 32'd0, 5'd8, 1'b1);
      chk("sz11_fault", 32'(out_fault), 32'd1);
      chk("sz11_req", 32'(mem_req), 32'd0);
      tick();
      issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h200, 32'd0, 32'd0, 5'd8, 1'b1);
      chk("ldst_fault", 32'(out_fault), 32'd1);
      chk("ldst_req", 32'(mem_req), 32'd0);
      tick();

      // passthrough
      issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'd0, 32'h000055AA, 5'd7, 1'b1);
      chk("pt_vld", 32'(out_valid), 32'd1);
      chk("pt_data", out_data, 32'h000055AA);
      chk("pt_fault", 32'(out_fault), 32'd0);
      chk("pt_bp", 32'(bp_valid), 32'd1);
      chk("pt_bprd", 32'(bp_rd), 32'd7);
      chk("pt_req", 32'(mem_req), 32'd0);
      chk("pt_in_ready", 32'(in_ready), 32'd1);
      tick();
      issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'd0, 32'h00001234, 5'd0, 1'b1);
      chk("pt_x0_bp", 32'(bp_valid), 32'd0);
      tick();

      // timeout with a late response
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h200, 32'd0, 32'd0, 5'd3, 1'b1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("to_wait_vld", 32'(out_valid), 32'd0);
         chk("to_wait_rdy", 32'(in_ready), 32'd0);
         tick();
      end
      chk("to_vld", 32'(out_valid), 32'd1);
      chk("to_fault", 32'(out_fault), 32'd1);
      chk("to_rdwe", 32'(out_rd_we), 32'd0);
      chk("to_data", out_data, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
      tick();
      mem_rvalid = 1'b0;
      chk("to_late_vld", 32'(out_valid), 32'd0);
      chk("to_in_ready", 32'(in_ready), 32'd1);

      // output back-pressure with a second op waiting upstream
      out_ready = 1'b0;
      issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'd0, 32'h00001111, 5'd9, 1'b1);
      in_result = 32'h00002222; in_rd = 5'd10; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_vld", 32'(out_valid), 32'd1);
         chk("hold_data", out_data, 32'h00001111);
         chk("hold_rd", 32'(out_rd), 32'd9);
         chk("hold_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk("rel_vld", 32'(out_valid), 32'd1);
      chk("rel_data", out_data, 32'h00002222);
      chk("rel_rd", 32'(out_rd), 32'd10);
      tick();
      chk("rel_vld_clr", 32'(out_valid), 32'd0);

      // reset during WAIT abandons the load; its response is ignored
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'd0, 32'd0, 5'd4, 1'b1);
      chk("rw_req", 32'(mem_req), 32'd1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("rw_in_ready_wait", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rw_req_rst", 32'(mem_req), 32'd0);
      chk("rw_vld_rst", 32'(out_valid), 32'd0);
      chk("rw_in_ready_rst", 32'(in_ready), 32'd1);
      tick();
      rst = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      tick();
      mem_rvalid = 1'b0;
      chk("rw_stale_vld", 32'(out_valid), 32'd0);
      chk("rw_in_ready", 32'(in_ready), 32'd1);

      // reset during REQ drops the request at once
      issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'd0, 32'd0, 5'd4, 1'b1);
      chk("rr_req", 32'(mem_req), 32'd1);
      rst = 1'b0;
      #1;
      chk("rr_req_rst", 32'(mem_req), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_hs.md
MEM_STAGE_HS -- requirements
Module: mem_stage_hs

Interface
REQ-001 Parameter ADDR_WIDTH, 32, byte-address width of in_addr and mem_addr.
REQ-002 Parameter TIMEOUT, 16, maximum cycles in WAIT before a load fault is declared; legal range 1..255.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  upstream op valid.
REQ-006 in_ready  out  1  stage can accept an op this cycle.
REQ-007 in_load / in_store  in  1 each  op class; both 0 means ALU passthrough; both 1 is illegal.
REQ-008 in_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
REQ-009 in_unsigned  in  1  zero-extend the load result.
REQ-010 in_addr  in  ADDR_WIDTH  effective byte address.
REQ-011 in_wdata, in_result  in  32 each  store data; ALU result for passthrough.
REQ-012 in_rd, in_rd_we  in  5, 1  destination register and its write enable.
REQ-013 mem_req, mem_we  out  1 each  request strobe and write flag.
REQ-014 mem_addr  out  ADDR_WIDTH  word-aligned address {in_addr[AW-1:2],2'b00}.
REQ-015 mem_be, mem_wdata  out  4, 32  byte enables and lane-replicated store data.
REQ-016 mem_gnt, mem_rvalid, mem_rdata  in  1, 1, 32  request grant, read response, read data.
REQ-017 out_valid, out_ready  out, in  1 each  writeback handshake.
REQ-018 out_data, out_rd, out_rd_we, out_fault  out  32, 5, 1, 1  registered writeback bundle.
REQ-019 bp_valid, bp_rd, bp_data  out  1, 5, 32  bypass view of the output register.

Function
REQ-020 FSM states: IDLE, REQ, WAIT; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-021 An op is accepted on in_valid && in_ready; all op fields are latched at acceptance.
REQ-022 Passthrough op: next cycle out_valid=1, out_data=in_result, out_rd_we=in_rd_we, out_fault=0; FSM stays IDLE.
REQ-023 Misalignment: half with addr[0]=1, word with addr[1:0]!=0, size 11, or load&store both set.
REQ-024 Misaligned op: no mem_req is issued; next cycle out_valid=1, out_fault=1, out_data=0, out_rd_we=0.
REQ-025 Aligned load or store: IDLE->REQ; mem_req=1 from the following cycle.
REQ-026 In REQ, mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until mem_gnt.
REQ-027 Byte enables: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-028 Store data replication: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
REQ-029 Store granted: REQ->IDLE; next cycle out_valid=1, out_rd_we=0, out_fault=0.
REQ-030 Load granted: REQ->WAIT; mem_rvalid is sampled only in WAIT, never in the grant cycle.
REQ-031 In WAIT on mem_rvalid: select the lane by addr[1:0], sign- or zero-extend per in_unsigned, go to IDLE.
REQ-032 After REQ-031, next cycle out_valid=1, out_data=extended value, out_rd_we=latched in_rd_we.
REQ-033 WAIT counter: cleared on entry, +1 per cycle without rvalid; on reaching TIMEOUT, go to IDLE.
REQ-034 Timeout result: out_valid=1, out_fault=1, out_rd_we=0, out_data=0.
REQ-035 mem_rvalid outside WAIT (late or stray) is ignored.
REQ-036 Output hold: while out_valid && !out_ready, all out_* registers hold and no completion overwrites them.
REQ-037 Output hold: a completion is stalled in the FSM until out_ready is asserted.
REQ-038 out_valid clears on out_ready unless a new result loads in the same cycle.
REQ-039 Bypass: bp_valid = out_valid && out_rd_we && out_rd!=0; bp_rd=out_rd; bp_data=out_data; combinational.

Reset
REQ-040 On rst low, immediately: state IDLE, mem_req=0, out_valid=0, out_fault=0, out_rd_we=0, out_data=0, out_rd=0, counter=0.
REQ-041 On rst low, any in-flight transaction is abandoned, and the response following reset is ignored.
REQ-042 in_ready is 1 in the first cycle after reset release.

Verification
REQ-043 LW 0x104, gnt +1 cycle, rvalid rdata=0xDEADBEEF +2 cycles -> out_data=0xDEADBEEF, out_rd_we=1, mem_be=1111.
REQ-044 LB 0x103 with rdata=0x80123456 -> out_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-045 SH 0x102 with wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, out_rd_we=0.
REQ-046 LW 0x102 -> no mem_req ever asserted, out_fault=1 one cycle after accept, bp_valid=0.
REQ-047 Load with TIMEOUT=4 and no rvalid -> out_fault=1 after 4 WAIT cycles; a later rvalid has no effect; in_ready=1 again.
REQ-048 out_ready=0 for 3 cycles with a result pending -> out_* held, in_ready=0; rst low during WAIT -> mem_req=0, out_valid=0 at once.
